// File: rtl/core_run_ctrl.sv
// core_run_ctrl: launch/halt control and run statistics for the 9-bit core.
// Optional watchdog halt (cause 3) is built only when CORE_RUN_WATCHDOG_EN is defined.
module core_run_ctrl #(
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 9,
  parameter int PC_LIMIT   = 2**PC_W-1,
  parameter int HALT_ZEROS = 1,
  parameter int CYC_W      = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  output logic               core_reset,
  output logic               run_en,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [CYC_W-1:0]   cycle_count,
  output logic [CYC_W-1:0]   instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_PC   = 2'd1;
  localparam logic [1:0] CAUSE_ZERO = 2'd2;
  localparam logic [1:0] CAUSE_WD   = 2'd3;

  localparam logic [CYC_W-1:0] CNT_MAX = '1;
  localparam logic [CYC_W-1:0] CNT_ONE = CYC_W'(1);
  localparam logic [PC_W-1:0]  PC_LIM  = PC_W'(PC_LIMIT);
  localparam logic [3:0]       ZR_LAST = 4'(HALT_ZEROS-1);

  state_e state_q, state_d;

  logic             start_q;
  logic             launch;
  logic             in_run;
  logic             retire;
  logic             instr_zero;
  logic             hit_pc;
  logic             hit_zero;
  logic             hit_wd;
  logic             halt;

  logic             core_reset_q, core_reset_d;
  logic             run_en_q, run_en_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;
  logic [3:0]       zero_run_q, zero_run_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] ins_q, ins_d;

  assign launch     = start & ~start_q;
  assign in_run     = (state_q == RUN);
  assign retire     = in_run & ~stall;
  assign instr_zero = (instr == '0);

  assign hit_pc   = retire & (pc == PC_LIM);
  assign hit_zero = retire & instr_zero & (zero_run_q == ZR_LAST);

`ifdef CORE_RUN_WATCHDOG_EN
  localparam logic [CYC_W-1:0] WD_LAST = CYC_W'(TIMEOUT-1);

  // Watchdog counts stalled cycles too, so it looks at cycle_count only.
  assign hit_wd = in_run & (cyc_q == WD_LAST);
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign hit_wd         = 1'b0;
`endif

  assign halt = hit_pc | hit_zero | hit_wd;

  // State, edge detector, registered outputs and run statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      core_reset_q <= 1'b1;
      run_en_q     <= 1'b0;
      done_q       <= 1'b0;
      cause_q      <= CAUSE_NONE;
      zero_run_q   <= 4'd0;
      cyc_q        <= '0;
      ins_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      core_reset_q <= core_reset_d;
      run_en_q     <= run_en_d;
      done_q       <= done_d;
      cause_q      <= cause_d;
      zero_run_q   <= zero_run_d;
      cyc_q        <= cyc_d;
      ins_q        <= ins_d;
    end
  end

  // Next state: launch only from IDLE/DONE, CLEAR is a single cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (halt) state_d = DONE;
      DONE:    if (launch) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Output and counter next values, decoded from the upcoming state.
  always_comb begin
    core_reset_d = 1'b0;
    run_en_d     = 1'b0;
    done_d       = 1'b0;
    cause_d      = cause_q;
    zero_run_d   = zero_run_q;
    cyc_d        = cyc_q;
    ins_d        = ins_q;

    unique case (state_d)
      IDLE:    core_reset_d = 1'b1;
      CLEAR:   core_reset_d = 1'b1;
      RUN:     run_en_d     = 1'b1;
      DONE:    done_d       = 1'b1;
      default: core_reset_d = 1'b1;
    endcase

    if (state_d == CLEAR) begin
      cause_d    = CAUSE_NONE;
      zero_run_d = 4'd0;
      cyc_d      = '0;
      ins_d      = '0;
    end else if (in_run) begin
      if (cyc_q != CNT_MAX)
        cyc_d = cyc_q + CNT_ONE;

      if (retire) begin
        if (ins_q != CNT_MAX)
          ins_d = ins_q + CNT_ONE;
        if (instr_zero)
          zero_run_d = zero_run_q + 4'd1;
        else
          zero_run_d = 4'd0;
      end

      if (hit_pc)
        cause_d = CAUSE_PC;
      else if (hit_zero)
        cause_d = CAUSE_ZERO;
      else if (hit_wd)
        cause_d = CAUSE_WD;
    end
  end

  assign core_reset  = core_reset_q;
  assign run_en      = run_en_q;
  assign done        = done_q;
  assign halt_cause  = cause_q;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Parametrised run-control block for the 9-bit accumulator-style core. It owns the program-level start/done handshake and holds the core in reset until a run is launched. It gates core execution, detects halt conditions (PC limit, a run of all-zero instructions, optional watchdog) and reports the halt cause plus cycle and instruction counts. It sits beside the program counter and instruction memory in the top level and replaces the ad-hoc done register there.

## Interface
Parameters:
- PC_W, 8: program counter width.
- INSTR_W, 9: instruction word width.
- PC_LIMIT, 2**PC_W-1: PC value that halts the run when an instruction at that PC executes.
- HALT_ZEROS, 1: number of consecutive executed all-zero instructions that halts the run; legal range is 1..15.
- CYC_W, 16: width of the cycle and instruction counters.
- TIMEOUT, 1000: watchdog limit in RUN cycles. Only used with CORE_RUN_WATCHDOG_EN; must satisfy 1 ≤ TIMEOUT ≤ 2**CYC_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  launch request; acts on a rising edge only.
- pc  in  PC_W  current core PC.
- instr  in  INSTR_W  instruction at pc.
- stall  in  1  core stalled this cycle; no instruction retires.
- core_reset  out  1  synchronous reset to PC and register file.
- run_en  out  1  core execute/commit enable.
- done  out  1  run finished; held until the next launch.
- halt_cause  out  2  0 none, 1 PC limit, 2 zero-instruction run, 3 watchdog.
- cycle_count  out  CYC_W  RUN cycles, stalls included.
- instr_count  out  CYC_W  retired (non-stalled) instructions.

## Operation
- States: IDLE, CLEAR, RUN, DONE. All outputs are registered.
- Reset values: state=IDLE, core_reset=1, run_en=0, done=0, halt_cause=0, both counts=0, internal start_q=0, zero_run=0.
- Launch: start & ~start_q, where start_q is start delayed one cycle. A launch is accepted only in IDLE or DONE. Launch moves the block to CLEAR.
- CLEAR lasts one cycle:
  - core_reset=1, run_en=0, done=0;
  - halt_cause, counts and zero_run clear to 0;
  - next state is RUN.
- RUN: core_reset=0, run_en=1.
  - cycle_count increments every cycle.
  - When stall=0, instr_count increments. zero_run increments if instr==0, otherwise it clears to 0.
  - When stall=1, instr_count, zero_run and halt checks are all frozen.
- Halt checks, evaluated in RUN with stall=0 on the retiring instruction, highest priority first:
  - cause 1: pc==PC_LIMIT;
  - cause 2: instr==0 and zero_run==HALT_ZEROS-1;
  - cause 3 (watchdog, checked regardless of stall): cycle_count==TIMEOUT-1.
- Any halt moves the block to DONE and latches halt_cause. The halting instruction is counted in instr_count.
- DONE: done=1, run_en=0, core_reset=0. Counters and halt_cause hold their values, so the core state stays readable.
- start activity in CLEAR or RUN is ignored, including rising edges.
- Counters saturate at all-ones and never wrap.
- reset in any state returns the block to IDLE with the reset values above within the same cycle (asynchronous).

## Timing
- Rising edge of start sampled at edge N: CLEAR is entered after N; RUN after N+1. The first instruction retires at edge N+2.
- A halting instruction sampled at edge M gives done=1, run_en=0 and a valid halt_cause after M. Nothing is committed after M.
- Relaunch from DONE needs start to go low for at least one sampled cycle first.
- Back-to-back runs: DONE → CLEAR → RUN takes 2 cycles from the accepted launch.

## Configuration
- CORE_RUN_WATCHDOG_EN defined: cause 3 is active and TIMEOUT is used.
- CORE_RUN_WATCHDOG_EN undefined: no watchdog logic is built and halt_cause never reads 3. A program that never halts stays in RUN, with cycle_count saturating.

## Test plan
- Defaults, instr nonzero at PC 0..4 and instr=0 at PC 5, launch at cycle 2 → core_reset drops at cycle 4; done=1 after PC 5 retires; halt_cause=2, instr_count=6, cycle_count=6.
- HALT_ZEROS=3, instruction stream 0,0,7,0,0,0 → the 7 resets zero_run; halt on the 6th instruction with cause 2 and instr_count=6.
- PC_LIMIT=10 with PC counting 0..10, all instr=1, stall=1 for 2 cycles mid-run → halt_cause=1, instr_count=11, cycle_count=13.
- Zero instruction at PC==PC_LIMIT → halt_cause=1 (priority). Hold start high through DONE → no relaunch until start goes low and then high again.
- CORE_RUN_WATCHDOG_EN with TIMEOUT=20, looping PC 0..3 with nonzero instr → done after 20 RUN cycles, halt_cause=3, cycle_count=20.
- Assert reset during RUN at cycle 7 → in the same cycle state=IDLE, core_reset=1, run_en=0, done=0, and all counts and halt_cause read 0.
